// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: selects one of NUM_MODES segment sources by a debounced push-button, with alert preemption
//   clk, rst            : 1 kHz clock, synchronous active-high reset
//   mode                : raw asynchronous mode push-button
//   alert               : per-source alert request levels
//   src_seg_data/com    : packed per-source segment data / digit commons (8 bits each)
//   seg_data/seg_com    : registered segment outputs of the displayed source
//   mode_sel            : user-selected source index
//   led                 : one-hot displayed source, bit 7 = alert active
module display_mode_ctrl #(
  parameter int NUM_MODES    = 3,
  parameter int DEBOUNCE_CYC = 20,
  parameter int ALERT_HOLD   = 3000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [NUM_MODES-1:0]   alert,
  input  logic [NUM_MODES*8-1:0] src_seg_data,
  input  logic [NUM_MODES*8-1:0] src_seg_com,
  output logic [7:0]             seg_data,
  output logic [7:0]             seg_com,
  output logic [2:0]             mode_sel,
  output logic [7:0]             led
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(ALERT_HOLD + 1);
  typedef enum logic {NORMAL, ALERT} state_t;
  state_t         r_state, w_state_nx;
  logic [1:0]     r_sync;
  logic           r_db, r_db_prev, w_pulse;
  logic [CW-1:0]  r_db_cnt;
  logic [NUM_MODES-1:0] r_alert_prev, w_rise;
  logic [2:0]     r_mode_sel, r_disp_sel, w_mode_nx, w_disp_nx, w_mode_inc, w_rise_idx;
  logic [HW-1:0]  r_hold_cnt, w_hold_nx;
  logic [7:0]     r_seg_data, r_seg_com, r_led, w_seg_data, w_seg_com;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= '0;
      r_db         <= 1'b0;
      r_db_prev    <= 1'b0;
      r_db_cnt     <= '0;
      r_alert_prev <= '0;
    end else begin
      r_sync       <= {r_sync[0], mode};
      r_db_prev    <= r_db;
      r_alert_prev <= alert;
      if (r_sync[1] != r_db) begin
        if (r_db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          r_db     <= r_sync[1];
          r_db_cnt <= '0;
        end else r_db_cnt <= r_db_cnt + 1'b1;
      end else r_db_cnt <= '0;
    end
  end
  assign w_pulse    = r_db & ~r_db_prev;
  assign w_rise     = alert & ~r_alert_prev;
  assign w_mode_inc = (r_mode_sel == 3'(NUM_MODES - 1)) ? 3'd0 : r_mode_sel + 3'd1;
  // Descending scan so the lowest rising index is the one left standing.
  always_comb begin
    w_rise_idx = 3'd0;
    for (int i = NUM_MODES - 1; i >= 0; i--) if (w_rise[i]) w_rise_idx = 3'(i);
  end
  // An alert edge takes priority over expiry and over a button pulse in either state.
  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode_sel;
    w_disp_nx  = r_disp_sel;
    w_hold_nx  = r_hold_cnt;
    if (|w_rise) begin
      w_state_nx = ALERT;
      w_disp_nx  = w_rise_idx;
      w_hold_nx  = HW'(ALERT_HOLD - 1);
    end else if (r_state == ALERT) begin
      if (w_pulse || r_hold_cnt == '0) begin
        w_state_nx = NORMAL;
        w_disp_nx  = r_mode_sel;
      end else w_hold_nx = r_hold_cnt - 1'b1;
    end else if (w_pulse) begin
      w_mode_nx = w_mode_inc;
      w_disp_nx = w_mode_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= NORMAL;
      r_mode_sel <= 3'd0;
      r_disp_sel <= 3'd0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode_sel <= w_mode_nx;
      r_disp_sel <= w_disp_nx;
      r_hold_cnt <= w_hold_nx;
    end
  end
  always_comb begin
    w_seg_data = 8'h00;
    w_seg_com  = 8'hFF;
    for (int i = 0; i < NUM_MODES; i++)
      if (r_disp_sel == 3'(i)) begin
        w_seg_data = src_seg_data[8*i +: 8];
        w_seg_com  = src_seg_com[8*i +: 8];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_data <= 8'h00;
      r_seg_com  <= 8'hFF;
      r_led      <= 8'h01;
    end else begin
      r_seg_data <= w_seg_data;
      r_seg_com  <= w_seg_com;
      r_led      <= {r_state == ALERT, 7'(7'b1 << r_disp_sel)};
    end
  end
  assign seg_data = r_seg_data;
  assign seg_com  = r_seg_com;
  assign led      = r_led;
  assign mode_sel = r_mode_sel;
endmodule

// File: tb/tb_display_mode_ctrl.sv
// tb_display_mode_ctrl: directed checks of debounce, mode cycling, alert preemption and reset
module tb_display_mode_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [2:0]  alert = 3'b000;
  logic [23:0] src_seg_data = {8'hC3, 8'hB2, 8'hA1};
  logic [23:0] src_seg_com  = {8'hFB, 8'hFD, 8'hFE};
  logic [7:0]  seg_data, seg_com, led;
  logic [2:0]  mode_sel;
  int          n_vec = 0;
  int          n_bad = 0;
  display_mode_ctrl #(.NUM_MODES(3), .DEBOUNCE_CYC(4), .ALERT_HOLD(10)) dut (
    .clk(clk), .rst(rst), .mode(mode), .alert(alert),
    .src_seg_data(src_seg_data), .src_seg_com(src_seg_com),
    .seg_data(seg_data), .seg_com(seg_com), .mode_sel(mode_sel), .led(led)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic press();
    mode = 1'b1;
    tick(12);
    mode = 1'b0;
    tick(12);
  endtask
  initial begin
    tick(2);
    chk("rst_seg_data", seg_data, 8'h00);
    chk("rst_seg_com", seg_com, 8'hFF);
    chk("rst_led", led, 8'h01);
    chk("rst_mode_sel", mode_sel, 3'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_seg_data", seg_data, 8'hA1);
    chk("idle_seg_com", seg_com, 8'hFE);
    mode = 1'b1;
    tick(6);
    chk("press_before", mode_sel, 3'd0);
    tick(1);
    chk("press_at", mode_sel, 3'd1);
    chk("press_seg_lag", seg_data, 8'hA1);
    tick(1);
    chk("press_seg", seg_data, 8'hB2);
    chk("press_com", seg_com, 8'hFD);
    chk("press_led", led, 8'h02);
    tick(12);
    chk("press_once", mode_sel, 3'd1);
    mode = 1'b0;
    tick(12);
    chk("release_nochg", mode_sel, 3'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      mode = 1'b1;
      tick(3);
      mode = 1'b0;
      tick(3);
    end
    tick(8);
    chk("glitch", mode_sel, 3'd0);
    press();
    chk("seq_1", mode_sel, 3'd1);
    press();
    chk("seq_2", mode_sel, 3'd2);
    chk("seq_2_led", led, 8'h04);
    press();
    chk("seq_0", mode_sel, 3'd0);
    alert = 3'b110;
    tick(2);
    chk("alert_led", led, 8'h82);
    chk("alert_seg", seg_data, 8'hB2);
    chk("alert_com", seg_com, 8'hFD);
    tick(9);
    chk("alert_hold_end", led, 8'h82);
    tick(1);
    chk("alert_expired_led", led, 8'h01);
    chk("alert_expired_seg", seg_data, 8'hA1);
    tick(15);
    chk("alert_level_no_retrig", led, 8'h01);
    alert = 3'b000;
    tick(1);
    alert = 3'b100;
    tick(1);
    mode = 1'b1;
    tick(1);
    chk("cancel_entered", led, 8'h84);
    tick(6);
    chk("cancel_before", led, 8'h84);
    tick(1);
    chk("cancel_led", led, 8'h01);
    chk("cancel_mode_sel", mode_sel, 3'd0);
    tick(4);
    mode = 1'b0;
    tick(12);
    chk("cancel_no_reentry", led, 8'h01);
    chk("cancel_mode_keep", mode_sel, 3'd0);
    press();
    chk("coll_setup", mode_sel, 3'd1);
    alert = 3'b000;
    tick(1);
    mode = 1'b1;
    tick(6);
    alert = 3'b100;
    tick(1);
    chk("coll_mode_sel", mode_sel, 3'd1);
    tick(1);
    chk("coll_led", led, 8'h84);
    chk("coll_seg", seg_data, 8'hC3);
    chk("coll_com", seg_com, 8'hFB);
    mode = 1'b0;
    tick(3);
    rst = 1'b1;
    alert = 3'b000;
    tick(1);
    chk("mid_rst_seg", seg_data, 8'h00);
    chk("mid_rst_com", seg_com, 8'hFF);
    chk("mid_rst_led", led, 8'h01);
    chk("mid_rst_mode_sel", mode_sel, 3'd0);
    rst = 1'b0;
    tick(12);
    chk("post_rst_led", led, 8'h01);
    chk("post_rst_mode_sel", mode_sel, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
